// File: rtl/arm_pkg.sv
// arm_pkg: state codes, datapath mux encodings and op encodings for main_fsm
package arm_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    MULWAIT  = 4'd10
  } state_t;
  localparam logic [1:0] SRC_A_REG  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;
  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_DATA       = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
endpackage

// File: rtl/main_fsm.sv
// main_fsm: multicycle ARM control FSM; MULTICYCLE_MUL_EN adds a multiply launch/wait path
module main_fsm
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] instr74,
  input  logic       cond_ex,
  input  logic       mem_ready,
  input  logic       mul_done,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       branch,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       alu_op,
  output logic       mul_start,
  output logic [3:0] state
);
  state_t cur, nxt;
  logic no_write;
  assign no_write = funct[4:3] == 2'b10;
  assign state = cur;
`ifdef MULTICYCLE_MUL_EN
  logic is_mul;
  assign is_mul = op == OP_DP && funct[5:4] == 2'b00 && instr74 == 4'b1001;
`else
  logic unused;
  assign unused = ^{mul_done, instr74};
`endif
  always_ff @(posedge clk)
    cur <= reset ? FETCH : nxt;
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE:   nxt = !cond_ex ? FETCH : op == OP_MEM ? MEMADR : op == OP_BR ? BRANCH :
                      op == OP_DP ? (funct[5] ? EXECI : EXECR) : FETCH;
      MEMADR:   nxt = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
`ifdef MULTICYCLE_MUL_EN
      EXECR:    nxt = is_mul ? MULWAIT : no_write ? FETCH : ALUWB;
      MULWAIT:  nxt = mul_done ? ALUWB : MULWAIT;
`else
      EXECR:    nxt = no_write ? FETCH : ALUWB;
`endif
      EXECI:    nxt = no_write ? FETCH : ALUWB;
      default:  nxt = FETCH;
    endcase
  end
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRC_A_REG;
    alu_src_b  = SRC_B_REG;
    result_src = RES_ALU_OUT;
    alu_op     = 1'b0;
    mul_start  = 1'b0;
    case (cur)
      FETCH: begin
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU_RESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU_RESULT;
      end
      MEMADR:   alu_src_b = SRC_B_IMM;
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECR: begin
        alu_op = 1'b1;
`ifdef MULTICYCLE_MUL_EN
        mul_start = is_mul;
`endif
      end
      EXECI: begin
        alu_src_b = SRC_B_IMM;
        alu_op    = 1'b1;
      end
      ALUWB:    reg_write = 1'b1;
      BRANCH: begin
        alu_src_b  = SRC_B_IMM;
        result_src = RES_ALU_RESULT;
        branch     = 1'b1;
      end
`ifdef MULTICYCLE_MUL_EN
      MULWAIT:  alu_op = 1'b1;
`endif
      default: ;
    endcase
    // enables must drop immediately on reset, even mid-stall
    if (reset) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      mul_start = 1'b0;
    end
  end
endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameters: none; all encodings are fixed in the shared package.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  2  instr[27:26]; 00 data-processing, 01 memory, 10 branch.
REQ-005 funct  input  6  instr[25:20]; [5] immediate, [4:1] cmd, [0] S/L.
REQ-006 instr74  input  4  instr[7:4]; 1001 with op=00, funct[5:4]=00 marks multiply.
REQ-007 cond_ex  input  1  condition-check result for the current instruction, valid in DECODE.
REQ-008 mem_ready  input  1  memory access completes this cycle.
REQ-009 mul_done  input  1  multiplier result valid (used only with MULTICYCLE_MUL_EN).
REQ-010 ir_write, pc_write, reg_write, mem_write, branch  output  1 each  enables.
REQ-011 adr_src  output  1  0 = PC, 1 = ALU result.
REQ-012 alu_src_a, alu_src_b, result_src  output  2 each  datapath mux selects.
REQ-013 alu_op  output  1  1 = decoder derives alu_ctl from funct; 0 = add.
REQ-014 mul_start  output  1  one-cycle multiplier launch pulse.
REQ-015 state  output  4  current state code, for debug and bench.

Function
REQ-016 Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, MULWAIT.
REQ-017 FETCH: adr_src=0, alu_src_a=01, alu_src_b=10, result_src=10; holds until mem_ready=1; ir_write=pc_write=1 only in the mem_ready=1 cycle; then DECODE.
REQ-018 DECODE: alu_src_a=01, alu_src_b=10, result_src=10; cond_ex=0 -> FETCH.
REQ-019 DECODE with cond_ex=1 transitions as follows: op=01 -> MEMADR; op=10 -> BRANCH; op=00 with funct[5]=1 -> EXECI; otherwise -> EXECR; op=11 -> FETCH (undefined, no writes).
REQ-020 MEMADR: alu_src_a=00, alu_src_b=01, alu_op=0; funct[0]=1 -> MEMREAD, else MEMWRITE.
REQ-021 MEMREAD: adr_src=1; holds until mem_ready=1, then MEMWB.
REQ-022 MEMWB: result_src=01, reg_write=1 for exactly one cycle; then FETCH.
REQ-023 MEMWRITE: adr_src=1, mem_write=1 held until mem_ready=1 inclusive; then FETCH.
REQ-024 EXECR: alu_src_a=00, alu_src_b=00, alu_op=1. EXECI: same except alu_src_b=01.
REQ-025 From EXECR or EXECI: funct[4:3]=10 (TST/TEQ/CMP/CMN) -> FETCH with no write; otherwise -> ALUWB.
REQ-026 ALUWB: result_src=00, reg_write=1 for one cycle; then FETCH.
REQ-027 BRANCH: alu_src_a=00, alu_src_b=01, result_src=10, branch=1 for one cycle; then FETCH.
REQ-028 Outputs not listed for a state SHALL be 0; unreachable state codes SHALL go to FETCH with all enables 0.
REQ-029 Minimum latency per instruction: DP 4 cycles (compare 3), LDR 5, STR 4, B 3, each plus memory wait cycles.

Reset
REQ-030 While reset=1, all enables and mul_start SHALL be 0; the cycle after reset deasserts, state=FETCH. This applies in every state, including mid-stall.
REQ-031 Reset SHALL abort an outstanding multiply; a late mul_done SHALL be ignored outside MULWAIT.

Configuration
REQ-032 Macro MULTICYCLE_MUL_EN.
REQ-033 Defined: a multiply detected in DECODE goes to EXECR, which pulses mul_start for one cycle, then MULWAIT; MULWAIT holds with alu_op=1 until mul_done=1, then ALUWB.
REQ-034 Undefined: multiply follows the plain EXECR->ALUWB path; mul_start is tied 0, MULWAIT is unreachable, and mul_done is ignored.

Structure
REQ-035 Package arm_pkg SHALL hold the state_t enum, the alu_src_a, alu_src_b and result_src encoding constants, and the op encodings.
REQ-036 The design is a single module with no sub-module; it uses a next-state always_comb and an output always_comb.

Verification
REQ-037 ADD reg (op=00, funct=001000), mem_ready=1, cond_ex=1 -> FETCH,DECODE,EXECR,ALUWB; reg_write=1 only in ALUWB.
REQ-038 LDR (op=01, funct=011001), mem_ready=0 for 2 cycles in MEMREAD -> MEMREAD lasts 3 cycles; reg_write in MEMWB only; total 7 cycles.
REQ-039 CMP (funct=010101) -> returns to FETCH after EXECR; reg_write never 1. cond_ex=0 on any instruction -> DECODE->FETCH, all writes 0.
REQ-040 B (op=10, funct=100000) -> branch=1 exactly in the third cycle; STR with mem_ready=1 -> mem_write high in exactly one cycle.
REQ-041 MULTICYCLE_MUL_EN defined, MUL (funct=000000, instr74=1001), mul_done after 4 cycles -> mul_start pulses once, MULWAIT lasts 4 cycles, then ALUWB.
REQ-042 reset=1 asserted in MEMWRITE with mem_ready=0 -> mem_write=0 in that cycle; the next cycle is FETCH.
